level_countdown_timer: RTL and testbench



---
 rtl/game_pkg.sv | 9 +
 rtl/level_countdown_timer_if.sv | 28 ++
 rtl/bin2bcd_2digit.sv | 11 +
 rtl/level_countdown_timer.sv | 72 +++++++
 tb/tb_level_countdown_timer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game types, time width and saturation helper.
package game_pkg;
  localparam int TIME_W = 8;
  localparam logic [TIME_W-1:0] MAX_TIME = 8'd99;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} timer_state_t;
  function automatic logic [TIME_W-1:0] sat_time(input logic [TIME_W:0] v, input logic [TIME_W-1:0] max);
    return (v > {1'b0, max}) ? max : v[TIME_W-1:0];
  endfunction
endpackage

// File: rtl/level_countdown_timer_if.sv
// level_countdown_timer_if: controller <-> timer bus; bonus inputs present only with TIMER_BONUS_EN.
interface level_countdown_timer_if;
  logic start_level;
  logic [game_pkg::TIME_W-1:0] timer_time;
  logic skip_level;
  logic pause;
`ifdef TIMER_BONUS_EN
  logic bonus_valid;
  logic [3:0] bonus_secs;
`endif
  logic [game_pkg::TIME_W-1:0] time_left;
  logic [3:0] time_tens;
  logic [3:0] time_ones;
  logic running;
  logic time_low;
  logic level_ended;
`ifdef TIMER_BONUS_EN
  modport master(output start_level, timer_time, skip_level, pause, bonus_valid, bonus_secs,
                 input time_left, time_tens, time_ones, running, time_low, level_ended);
  modport slave(input start_level, timer_time, skip_level, pause, bonus_valid, bonus_secs,
                output time_left, time_tens, time_ones, running, time_low, level_ended);
`else
  modport master(output start_level, timer_time, skip_level, pause,
                 input time_left, time_tens, time_ones, running, time_low, level_ended);
  modport slave(input start_level, timer_time, skip_level, pause,
                output time_left, time_tens, time_ones, running, time_low, level_ended);
`endif
endinterface

// File: rtl/bin2bcd_2digit.sv
// bin2bcd_2digit: combinational 0..99 binary to two BCD digits.
module bin2bcd_2digit (
  input  logic [7:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  always_comb begin
    tens = 4'(bin / 8'd10);
    ones = 4'(bin % 8'd10);
  end
endmodule

// File: rtl/level_countdown_timer.sv
// level_countdown_timer: per-level countdown with pause, skip, BCD display and low-time warning.
// Optional TIMER_BONUS_EN adds bonus seconds while running or paused.
module level_countdown_timer #(
  parameter int TICKS_PER_SEC = 31_500_000,
  parameter logic [game_pkg::TIME_W-1:0] LOW_TIME_THRESH = 8'd10,
  parameter logic [game_pkg::TIME_W-1:0] MAX_TIME = game_pkg::MAX_TIME
) (
  input logic clk,
  input logic resetN,
  level_countdown_timer_if.slave bus
);
  import game_pkg::*;
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  timer_state_t state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic ended_q, ended_d, low_q, low_d, tick;
  logic [TIME_W:0] sum, bonus;
`ifdef TIMER_BONUS_EN
  assign bonus = bus.bonus_valid ? (TIME_W+1)'(bus.bonus_secs) : '0;
`else
  assign bonus = '0;
`endif
  assign tick = (state_q == RUN) && (presc_q == PW'(TICKS_PER_SEC - 1));
  // tick only occurs with time_q >= 1, so the subtraction cannot underflow
  assign sum = {1'b0, time_q} + bonus - (TIME_W+1)'(tick);
  always_comb begin
    state_d = state_q;
    time_d = time_q;
    presc_d = presc_q;
    ended_d = 1'b0;
    if (bus.start_level) begin
      time_d = sat_time({1'b0, bus.timer_time}, MAX_TIME);
      presc_d = '0;
      state_d = RUN;
    end else if (bus.skip_level && state_q != IDLE) begin
      state_d = IDLE;
    end else if (state_q == RUN && (time_q == '0 || (tick && sum == '0))) begin
      time_d = '0;
      state_d = EXPIRED;
      ended_d = 1'b1;
    end else if (state_q == RUN) begin
      time_d = sat_time(sum, MAX_TIME);
      presc_d = tick ? '0 : (bus.pause ? presc_q : presc_q + 1'b1);
      state_d = (!tick && bus.pause) ? PAUSE : RUN;
    end else if (state_q == PAUSE) begin
      time_d = sat_time(sum, MAX_TIME);
      state_d = bus.pause ? PAUSE : RUN;
    end
    low_d = (state_d == RUN || state_d == PAUSE) && time_d != '0 && time_d <= LOW_TIME_THRESH;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      time_q <= '0;
      presc_q <= '0;
      ended_q <= 1'b0;
      low_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q <= time_d;
      presc_q <= presc_d;
      ended_q <= ended_d;
      low_q <= low_d;
    end
  end
  assign bus.time_left = time_q;
  assign bus.running = (state_q == RUN) || (state_q == PAUSE);
  assign bus.time_low = low_q;
  assign bus.level_ended = ended_q;
  bin2bcd_2digit u_bcd (.bin(time_q), .tens(bus.time_tens), .ones(bus.time_ones));
endmodule

// File: tb/tb_level_countdown_timer.sv
// tb_level_countdown_timer: directed self-checking bench, TICKS_PER_SEC=4.
module tb_level_countdown_timer;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int total = 0;
  int fails = 0;
  int pulses = 0;
  level_countdown_timer_if bus();
  level_countdown_timer #(.TICKS_PER_SEC(4)) dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.level_ended === 1'b1) pulses++;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [7:0] t);
    bus.start_level = 1'b1;
    bus.timer_time = t;
    cyc(1);
    bus.start_level = 1'b0;
  endtask
  task automatic skip();
    bus.skip_level = 1'b1;
    cyc(1);
    bus.skip_level = 1'b0;
  endtask
  initial begin
    bus.start_level = 1'b0;
    bus.timer_time = '0;
    bus.skip_level = 1'b0;
    bus.pause = 1'b0;
`ifdef TIMER_BONUS_EN
    bus.bonus_valid = 1'b0;
    bus.bonus_secs = '0;
`endif
    cyc(3);
    chk("rst_time", bus.time_left, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_low", bus.time_low, 0);
    chk("rst_ended", bus.level_ended, 0);
    chk("rst_bcd", {bus.time_tens, bus.time_ones}, 0);
    resetN = 1'b1;
    cyc(2);
    pulses = 0;
    load(8'd3);
    chk("t3_load", bus.time_left, 3);
    chk("t3_running", bus.running, 1);
    chk("t3_low", bus.time_low, 1);
    cyc(3);
    chk("t3_hold", bus.time_left, 3);
    cyc(1);
    chk("t3_dec2", bus.time_left, 2);
    cyc(4);
    chk("t3_dec1", bus.time_left, 1);
    chk("t3_noend", bus.level_ended, 0);
    cyc(4);
    chk("t3_zero", bus.time_left, 0);
    chk("t3_ended", bus.level_ended, 1);
    chk("t3_stopped", bus.running, 0);
    chk("t3_low0", bus.time_low, 0);
    cyc(1);
    chk("t3_pulse_off", bus.level_ended, 0);
    cyc(8);
    chk("t3_one_pulse", pulses, 1);
    chk("t3_exp_hold", bus.time_left, 0);
    load(8'd150);
    chk("sat_time", bus.time_left, 99);
    chk("sat_bcd", {bus.time_tens, bus.time_ones}, 8'h99);
    chk("sat_low", bus.time_low, 0);
    skip();
    chk("sat_skip_hold", bus.time_left, 99);
    chk("sat_skip_idle", bus.running, 0);
    load(8'd12);
    cyc(4);
    chk("p_dec11", bus.time_left, 11);
    cyc(1);
    bus.pause = 1'b1;
    cyc(20);
    chk("p_frozen", bus.time_left, 11);
    chk("p_running", bus.running, 1);
    chk("p_low", bus.time_low, 0);
    chk("p_bcd", {bus.time_tens, bus.time_ones}, 8'h11);
    bus.pause = 1'b0;
    cyc(3);
    chk("p_partial", bus.time_left, 11);
    cyc(1);
    chk("p_resume_dec", bus.time_left, 10);
    chk("p_low10", bus.time_low, 1);
    skip();
    load(8'd5);
    cyc(6);
    chk("s_dec4", bus.time_left, 4);
    skip();
    chk("s_hold", bus.time_left, 4);
    chk("s_idle", bus.running, 0);
    chk("s_low", bus.time_low, 0);
    cyc(10);
    chk("s_still", bus.time_left, 4);
    chk("s_nopulse", pulses, 1);
    load(8'd4);
    chk("s_reload", bus.time_left, 4);
    chk("s_rerun", bus.running, 1);
    load(8'd0);
    chk("z_time", bus.time_left, 0);
    chk("z_running", bus.running, 1);
    chk("z_noend_yet", bus.level_ended, 0);
    chk("z_low_a", bus.time_low, 0);
    cyc(1);
    chk("z_ended", bus.level_ended, 1);
    chk("z_low_b", bus.time_low, 0);
    cyc(1);
    chk("z_pulse_off", bus.level_ended, 0);
    chk("z_pulses", pulses, 2);
    load(8'd11);
    chk("l_11_low", bus.time_low, 0);
    cyc(4);
    chk("l_10", bus.time_left, 10);
    chk("l_10_low", bus.time_low, 1);
    chk("l_10_bcd", {bus.time_tens, bus.time_ones}, 8'h10);
    cyc(2);
    resetN = 1'b0;
    #1;
    chk("ar_time", bus.time_left, 0);
    chk("ar_running", bus.running, 0);
    chk("ar_low", bus.time_low, 0);
    cyc(2);
    resetN = 1'b1;
    cyc(6);
    chk("ar_nopulse", pulses, 2);
`ifdef TIMER_BONUS_EN
    load(8'd1);
    cyc(3);
    bus.bonus_valid = 1'b1;
    bus.bonus_secs = 4'd5;
    cyc(1);
    bus.bonus_valid = 1'b0;
    chk("b_save", bus.time_left, 5);
    chk("b_noend", bus.level_ended, 0);
    chk("b_running", bus.running, 1);
    cyc(2);
    chk("b_nopulse", pulses, 2);
    load(8'd97);
    bus.bonus_valid = 1'b1;
    cyc(1);
    bus.bonus_valid = 1'b0;
    chk("b_sat", bus.time_left, 99);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
